// File: rtl/sdra_pkg.sv
// Shared definitions for the DivMMC SD SPI read-ahead engine.
//  - Default I/O port numbers for the SPI data port and the read-ahead arm port.
//  - Engine FSM state encoding.
//  - BYTE_CLKS: system clocks per SPI byte (SCLK = clk/2, 8 bits).
package sdra_pkg;

  localparam logic [7:0]  SPI_PORT_DEF = 8'hEB;
  localparam logic [7:0]  RA_PORT_DEF  = 8'hEF;
  localparam int unsigned BYTE_CLKS    = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } eng_state_e;

endpackage

// File: rtl/sd_ra_fifo.sv
// Read-ahead byte FIFO, DEPTH x 8.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  push, wdata    write one byte (ignored when full)
//  pop            drop the head byte (ignored when empty)
//  flush          synchronous clear; wins over push/pop in the same cycle
//  rdata          head byte (valid when !empty)
//  full, empty    status
//  count          occupancy, log2(DEPTH)+1 bits
module sd_ra_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  // Occupancy never exceeds DEPTH (a power of 2), so the MSB alone marks full.
  assign full    = count_q[AW];
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/sd_spi_readahead.sv
// DivMMC SD SPI engine with read-ahead FIFO.
// Ports:
//  clk, rst_n          system clock (SCLK = clk/2), asynchronous active-low reset
//  a, iorq_n, rd_n,    Z80 low address byte and strobes (strobes asynchronous to clk)
//  wr_n, d_in
//  d_out, d_oe         read data and bus drive enable (d_oe is combinational)
//  wait_n              Z80 WAIT, low = stall
//  sd_sclk, sd_mosi,   SPI pins, SCLK idle 0, MOSI idle 1, MSB first
//  sd_miso
// Build option: define SDRA_WAIT_EN to stall underrunning reads with wait_n; otherwise wait_n
// is tied high and an underrun returns the stale last received byte.
module sd_spi_readahead
  import sdra_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  SPI_PORT = SPI_PORT_DEF,
  parameter logic [7:0]  RA_PORT  = RA_PORT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       wait_n,
  output logic       sd_sclk,
  output logic       sd_mosi,
  input  logic       sd_miso
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  eng_state_e state_q, state_d;

  logic [1:0] rd_sync_q, wr_sync_q;
  logic       rd_prev_q, wr_prev_q;
  logic       rd_act_q, rd_pend_q, wr_pend_q, ra_q;
  logic [7:0] wr_data_q, tx_q, rx_q, last_rx_q;
  logic [8:0] budget_q;
  logic [3:0] cnt_q;

  logic       rd_fall, rd_rise, wr_fall;
  logic       rd_go, rd_end, wr_spi_go, wr_ra_go, flush;
  logic       start_wr, start_rd, start_ra, start_any;
  logic       f_push, f_pop, f_full, f_empty;
  logic [7:0] f_head;
  logic [CW-1:0] f_count;

  // Strobe edge detection on the synchronised, active-low combined strobes.
  assign rd_fall   = rd_prev_q && !rd_sync_q[1];
  assign rd_rise   = !rd_prev_q && rd_sync_q[1];
  assign wr_fall   = wr_prev_q && !wr_sync_q[1];
  assign rd_go     = rd_fall && (a == SPI_PORT);
  // The port decode is latched at the falling edge, so the end of the read does not depend
  // on the address still being valid when rd_n rises.
  assign rd_end    = rd_rise && rd_act_q;
  assign wr_spi_go = wr_fall && (a == SPI_PORT);
  assign wr_ra_go  = wr_fall && (a == RA_PORT);
  assign flush     = wr_spi_go || wr_ra_go;

  // Read-ahead also holds off for one cycle when a read is completing, so a legacy request
  // queued by that read gets the engine first.
  assign start_wr  = (state_q == StIdle) && wr_pend_q;
  assign start_rd  = (state_q == StIdle) && !wr_pend_q && rd_pend_q;
  assign start_ra  = (state_q == StIdle) && !wr_pend_q && !rd_pend_q && (budget_q != '0) &&
                     (f_count < CW'(DEPTH)) && !rd_end && !flush;
  assign start_any = start_wr || start_rd || start_ra;

  assign f_pop     = rd_end && !f_empty;

  assign d_oe  = (a == SPI_PORT) && !iorq_n && !rd_n;
  assign d_out = f_empty ? last_rx_q : f_head;

`ifdef SDRA_WAIT_EN
  assign wait_n = !(d_oe && f_empty && ((budget_q != '0) || ((state_q != StIdle) && ra_q)));
`else
  assign wait_n = 1'b1;
`endif

  sd_ra_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (f_pop),
    .flush (flush),
    .wdata (rx_q),
    .rdata (f_head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  push_never_full: assert property (@(posedge clk) disable iff (!rst_n) !(f_push && f_full));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_any) state_d = StShift;
      StShift: if (cnt_q == 4'(BYTE_CLKS - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    sd_sclk = 1'b0;
    sd_mosi = 1'b1;
    f_push  = 1'b0;
    unique case (state_q)
      StShift: begin
        sd_sclk = cnt_q[0];
        sd_mosi = tx_q[7];
      end
      StDone:  f_push = ra_q;
      default: ;
    endcase
  end

  // Synchronisers, request bookkeeping and shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q <= 2'b11;
      wr_sync_q <= 2'b11;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
      rd_act_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= 8'hFF;
      budget_q  <= '0;
      ra_q      <= 1'b0;
      cnt_q     <= '0;
      tx_q      <= 8'hFF;
      rx_q      <= 8'hFF;
      last_rx_q <= 8'hFF;
    end else begin
      rd_sync_q <= {rd_sync_q[0], iorq_n | rd_n};
      wr_sync_q <= {wr_sync_q[0], iorq_n | wr_n};
      rd_prev_q <= rd_sync_q[1];
      wr_prev_q <= wr_sync_q[1];

      if (rd_go)        rd_act_q <= 1'b1;
      else if (rd_rise) rd_act_q <= 1'b0;

      if (wr_spi_go) begin
        wr_pend_q <= 1'b1;
        wr_data_q <= d_in;
      end else if (start_wr) begin
        wr_pend_q <= 1'b0;
      end

      if (rd_end && f_empty && (budget_q == '0)) rd_pend_q <= 1'b1;
      else if (start_rd)                         rd_pend_q <= 1'b0;

      if (wr_spi_go)     budget_q <= '0;
      else if (wr_ra_go) budget_q <= {1'b0, d_in} + 9'd1;
      else if (start_ra) budget_q <= budget_q - 9'd1;

      // A flush also drops the byte in flight so it never lands in the emptied FIFO.
      if (flush)          ra_q <= 1'b0;
      else if (start_any) ra_q <= start_ra;

      if (start_any) begin
        cnt_q <= '0;
        tx_q  <= start_wr ? wr_data_q : 8'hFF;
      end else if (state_q == StShift) begin
        cnt_q <= cnt_q + 4'd1;
        // cnt_q[0] high means SCLK falls at this edge: sample MISO, then present next MOSI bit.
        if (cnt_q[0]) begin
          rx_q <= {rx_q[6:0], sd_miso};
          tx_q <= {tx_q[6:0], 1'b1};
        end
      end

      if (state_q == StDone) last_rx_q <= rx_q;
    end
  end

endmodule

// File: tb/tb_sd_spi_readahead.sv
// Directed bench for sd_spi_readahead: table of legacy-mode accesses plus hand-written
// read-ahead, flush, underrun and reset sequences against a byte-queue SD card model.
module tb_sd_spi_readahead;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe, wait_n, sd_sclk, sd_mosi, sd_miso;

  int total = 0;
  int bad   = 0;

  // Card model state.
  logic [7:0] card_q [$];
  logic [7:0] cur = 8'hFF;
  logic [7:0] mosi_sh = 8'hFF;
  logic [7:0] last_mosi = 8'hFF;
  int         nb = 0;
  int         pulses = 0;
  int         bytes_done = 0;

  always #5 clk = ~clk;

  sd_spi_readahead dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .d_in    (d_in),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .wait_n  (wait_n),
    .sd_sclk (sd_sclk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso)
  );

  assign sd_miso = cur[7];

  // SPI mode 0 card: loads a reply byte on the first rising edge, shifts on falling edges.
  always @(sd_sclk or negedge rst_n) begin
    if (!rst_n) begin
      nb  = 0;
      cur = 8'hFF;
    end else if (sd_sclk === 1'b1) begin
      if (nb == 0) cur = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
      mosi_sh = {mosi_sh[6:0], sd_mosi};
      pulses++;
    end else if (sd_sclk === 1'b0) begin
      cur = {cur[6:0], 1'b1};
      nb++;
      if (nb == 8) begin
        nb = 0;
        last_mosi = mosi_sh;
        bytes_done++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data, input int hold,
                           input int tail);
    @(negedge clk);
    a = addr; d_in = data; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (hold) @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (tail) @(negedge clk);
    a = 8'h00;
  endtask

  task automatic cpu_read(input logic [7:0] addr, input int hold, input int tail,
                          output logic [7:0] data, output logic oe, output logic saw_wait);
    int g;
    @(negedge clk);
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (hold) @(negedge clk);
    saw_wait = !wait_n;
    g = 0;
    while (!wait_n && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!wait_n) begin
      total++;
      bad++;
      $display("FAIL wait_timeout: got wait_n=0 want 1");
    end
    data = d_out;
    oe   = d_oe;
    rd_n = 1'b1; iorq_n = 1'b1;
    repeat (tail) @(negedge clk);
    a = 8'h00;
  endtask

  typedef struct {
    logic       is_wr;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] resp;
    logic [7:0] exp_rd;
    logic       exp_oe;
    int         exp_pulses;
    logic [7:0] exp_mosi;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, exp;
    logic       oe, sw;
    int         p0, b0, g;

    vecs[0] = '{1'b0, 8'hEB, 8'h00, 8'h3C, 8'hFF, 1'b1, 8, 8'hFF};
    vecs[1] = '{1'b1, 8'hEB, 8'h40, 8'hA5, 8'h00, 1'b0, 8, 8'h40};
    vecs[2] = '{1'b0, 8'hEB, 8'h00, 8'h5A, 8'hA5, 1'b1, 8, 8'hFF};
    vecs[3] = '{1'b0, 8'hEB, 8'h00, 8'h00, 8'h5A, 1'b1, 8, 8'hFF};
    vecs[4] = '{1'b1, 8'hEB, 8'hC3, 8'h81, 8'h00, 1'b0, 8, 8'hC3};
    vecs[5] = '{1'b0, 8'hEB, 8'h00, 8'h7E, 8'h81, 1'b1, 8, 8'hFF};
    vecs[6] = '{1'b0, 8'h12, 8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h00};
    vecs[7] = '{1'b1, 8'h12, 8'h55, 8'h00, 8'h00, 1'b0, 0, 8'h00};
    vecs[8] = '{1'b0, 8'hEF, 8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h00};
    vecs[9] = '{1'b0, 8'hEB, 8'h00, 8'h99, 8'h7E, 1'b1, 8, 8'hFF};

    rst_n = 1'b0; a = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; d_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mosi", sd_mosi, 1'b1);
    check("rst_sclk", sd_sclk, 1'b0);
    check("rst_oe", d_oe, 1'b0);
    check("rst_wait", wait_n, 1'b1);
    check("rst_dout", d_out, 8'hFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Legacy one-byte-per-access behaviour.
    for (int i = 0; i < NV; i++) begin
      p0 = pulses;
      if (vecs[i].exp_pulses != 0) card_q.push_back(vecs[i].resp);
      if (vecs[i].is_wr) begin
        cpu_write(vecs[i].port, vecs[i].data, 4, 5);
      end else begin
        cpu_read(vecs[i].port, 4, 5, rd, oe, sw);
        check($sformatf("v%0d_oe", i), oe, vecs[i].exp_oe);
        if (vecs[i].exp_oe) check($sformatf("v%0d_data", i), rd, vecs[i].exp_rd);
      end
      repeat (30) @(negedge clk);
      check($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
      if (vecs[i].exp_pulses != 0)
        check($sformatf("v%0d_mosi", i), last_mosi, vecs[i].exp_mosi);
    end

    // Arm 4 bytes: FIFO fills, engine stops, reads drain with no extra clocks.
    card_q.push_back(8'h11); card_q.push_back(8'h22);
    card_q.push_back(8'h33); card_q.push_back(8'h44);
    p0 = pulses;
    cpu_write(8'hEF, 8'h03, 4, 5);
    repeat (100) @(negedge clk);
    check("ra4_pulses", pulses - p0, 32);
    repeat (50) @(negedge clk);
    check("ra4_stopped", pulses - p0, 32);
    for (int i = 0; i < 4; i++) begin
      cpu_read(8'hEB, 4, 5, rd, oe, sw);
      exp = 8'h11 * 8'(i + 1);
      check($sformatf("ra4_rd%0d", i), rd, exp);
    end
    repeat (20) @(negedge clk);
    check("ra4_no_extra", pulses - p0, 32);
    card_q.push_back(8'h6B);
    cpu_read(8'hEB, 4, 5, rd, oe, sw);
    check("ra4_after_legacy_data", rd, 8'h44);
    repeat (30) @(negedge clk);
    check("ra4_after_legacy_pulses", pulses - p0, 40);

    // Arm 256 bytes, read them all at a pace slower than the engine.
    for (int i = 0; i < 256; i++) card_q.push_back(8'(i) ^ 8'h3C);
    p0 = pulses;
    cpu_write(8'hEF, 8'hFF, 4, 5);
    repeat (80) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      cpu_read(8'hEB, 4, 14, rd, oe, sw);
      check($sformatf("ra256_rd%0d", i), rd, 8'(i) ^ 8'h3C);
    end
    repeat (60) @(negedge clk);
    check("ra256_pulses", pulses - p0, 2048);
    card_q.push_back(8'h2D);
    cpu_read(8'hEB, 4, 5, rd, oe, sw);
    check("ra256_257th_data", rd, 8'hC3);
    repeat (30) @(negedge clk);
    check("ra256_257th_pulses", pulses - p0, 2056);

    // Write to the SPI port mid read-ahead: flush, cancel budget, one write transfer.
    card_q.push_back(8'h01); card_q.push_back(8'h02);
    card_q.push_back(8'h03); card_q.push_back(8'h04);
    p0 = pulses;
    b0 = bytes_done;
    cpu_write(8'hEF, 8'h03, 4, 1);
    g = 0;
    while (bytes_done < b0 + 2 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("flush_two_buffered", bytes_done - b0, 2);
    cpu_write(8'hEB, 8'hFF, 4, 5);
    repeat (60) @(negedge clk);
    check("flush_pulses", pulses - p0, 32);
    check("flush_mosi", last_mosi, 8'hFF);
    card_q.push_back(8'h5C);
    p0 = pulses;
    cpu_read(8'hEB, 4, 5, rd, oe, sw);
    check("flush_read_data", rd, 8'h04);
    repeat (30) @(negedge clk);
    check("flush_read_pulses", pulses - p0, 8);

    // Underrun: read right after arming, before any byte has been buffered.
    card_q.push_back(8'h71); card_q.push_back(8'h72);
    card_q.push_back(8'h73); card_q.push_back(8'h74);
    p0 = pulses;
    cpu_write(8'hEF, 8'h03, 2, 1);
    cpu_read(8'hEB, 2, 5, rd, oe, sw);
`ifdef SDRA_WAIT_EN
    check("under_wait_seen", sw, 1'b1);
    check("under_first", rd, 8'h71);
    repeat (100) @(negedge clk);
    check("under_pulses", pulses - p0, 32);
    for (int i = 1; i < 4; i++) begin
      cpu_read(8'hEB, 4, 5, rd, oe, sw);
      check($sformatf("under_rd%0d", i), rd, 8'h71 + 8'(i));
    end
`else
    check("under_stale", rd, 8'h5C);
    repeat (100) @(negedge clk);
    check("under_pulses", pulses - p0, 32);
    for (int i = 0; i < 4; i++) begin
      cpu_read(8'hEB, 4, 5, rd, oe, sw);
      check($sformatf("under_rd%0d", i), rd, 8'h71 + 8'(i));
    end
`endif
    repeat (20) @(negedge clk);
    check("under_no_extra", pulses - p0, 32);

    // Reset in the middle of a shift.
    card_q.push_back(8'h11);
    @(negedge clk);
    a = 8'hEB; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (4) @(negedge clk);
    rd_n = 1'b1; iorq_n = 1'b1;
    g = 0;
    while (sd_sclk !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("midrst_in_shift", sd_sclk, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_sclk", sd_sclk, 1'b0);
    check("midrst_mosi", sd_mosi, 1'b1);
    check("midrst_wait", wait_n, 1'b1);
    check("midrst_dout", d_out, 8'hFF);
    card_q.delete();
    repeat (3) @(negedge clk);
    a = 8'h00;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    p0 = pulses;
    card_q.push_back(8'hE1);
    cpu_read(8'hEB, 4, 5, rd, oe, sw);
    check("midrst_read_data", rd, 8'hFF);
    repeat (30) @(negedge clk);
    check("midrst_read_pulses", pulses - p0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
